// File: rtl/hisoc_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// image word width and default memory depth.
package hisoc_loader_pkg;

  localparam int IMEM_WORD_W        = 32;
  localparam int IMEM_DEPTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready image word stream feeding the instruction-memory loader.
// master = image source, slave = loader.
interface imem_loader_if;
  import hisoc_loader_pkg::*;

  logic                   s_valid;
  logic                   s_ready;
  logic [IMEM_WORD_W-1:0] s_data;
  logic                   s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/imem_loader_csum.sv
// 32-bit additive checksum accumulator for the image loader. The running sum
// is cleared at the start of each load, accumulates every non-checksum word
// and is compared combinationally against the checksum word.
module imem_loader_csum
  import hisoc_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   add,
  input  logic [IMEM_WORD_W-1:0] add_data,
  input  logic [IMEM_WORD_W-1:0] cmp_data,
  output logic                   match
);

  logic [IMEM_WORD_W-1:0] sum_q;

  // Running sum modulo 2^32; clear wins over add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (add) begin
      sum_q <= sum_q + add_data;
    end
  end

  assign match = (sum_q == cmp_data);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a program image over a valid/ready word
// stream, writes it to instruction memory one cycle after each transfer, then
// releases the core from reset after a settle window.
// Build option: define IMEM_LOADER_CSUM_EN to treat the s_last word as an
// additive checksum of the image instead of an instruction.
//
// state | meaning
// IDLE  | no image loaded, core held in reset
// LOAD  | accepting image words, core held in reset
// HOLD  | image complete, settle window counting down, core held in reset
// RUN   | core released (done reflects image quality)
module imem_loader
  import hisoc_loader_pkg::*;
#(
  parameter int DEPTH          = IMEM_DEPTH_DEFAULT,
  parameter int AW             = $clog2(DEPTH),
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  imem_loader_if.slave           s,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [IMEM_WORD_W-1:0] mem_wdata,
  output logic                   core_rst_n,
  output logic [AW:0]            word_cnt,
  output logic                   done,
  output logic                   err
);

  // The hold counter runs RELEASE_CYCLES..0 so the core leaves reset
  // RELEASE_CYCLES+1 cycles after the final memory write cycle.
  localparam int              HW        = $clog2(RELEASE_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(RELEASE_CYCLES);
  localparam logic [AW:0]     CNT_FULL  = (AW + 1)'(DEPTH);

  loader_state_e state_q;
  logic [HW-1:0] hold_cnt_q;
  logic          csum_bad_q;
  logic          xfer;
  logic          start_load;
  logic          write_word;
  logic          csum_match;

  assign s.s_ready  = (state_q == ST_LOAD);
  assign xfer       = s.s_valid && s.s_ready;
  assign start_load = load_start && ((state_q == ST_IDLE) || (state_q == ST_RUN));

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;

  imem_loader_csum u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_load),
    .add      (xfer && !s.s_last),
    .add_data (s.s_data),
    .cmp_data (s.s_data),
    .match    (csum_match)
  );
`else
  localparam bit CSUM_EN = 1'b0;

  assign csum_match = 1'b1;
`endif

  // The checksum word is consumed, never written to memory.
  assign write_word = xfer && !(CSUM_EN && s.s_last);

  // Loader FSM with registered memory-write and core-control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      csum_bad_q <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      word_cnt   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (start_load) begin
            state_q    <= ST_LOAD;
            word_cnt   <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            core_rst_n <= 1'b0;
            csum_bad_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (write_word) begin
            if (word_cnt == CNT_FULL) begin
              err <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[AW-1:0];
              mem_wdata <= s.s_data;
              word_cnt  <= word_cnt + 1'b1;
            end
          end
          if (xfer && s.s_last) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_INIT;
            if (CSUM_EN && !csum_match) begin
              err        <= 1'b1;
              csum_bad_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == '0) begin
            if (csum_bad_q) begin
              state_q <= ST_IDLE;
            end else begin
              state_q    <= ST_RUN;
              core_rst_n <= 1'b1;
              done       <= !err;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A driver issues image words with
// varying valid patterns; an abstract model predicts memory writes into a
// queue that an independent monitor drains on every mem_we. Load-level
// results (word count, error, release timing) are checked after each image.
module tb_imem_loader;
  import hisoc_loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int REL   = 4;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   load_start = 1'b0;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [IMEM_WORD_W-1:0] mem_wdata;
  logic                   core_rst_n;
  logic [AW:0]            word_cnt;
  logic                   done;
  logic                   err;

  imem_loader_if sif ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .RELEASE_CYCLES(REL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .s          (sif),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .word_cnt   (word_cnt),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] exp_q[$];
  logic [31:0] img[$];

  int          m_cnt;
  bit          m_err;
  bit          m_bad;
  logic [31:0] m_sum;
  bit          tog;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every memory write must match the oldest predicted write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        chk("mem_write", {24'h0, mem_addr, mem_wdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Abstract image model: words land at consecutive addresses until the
  // memory is full, extra words flag an error, checksum word is compared.
  task automatic model_xfer(input logic [31:0] w, input bit last);
    if (CSUM && last) begin
      m_bad = (m_sum != w);
    end else begin
      if (m_cnt < DEPTH) begin
        exp_q.push_back({8'(m_cnt), w});
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
      m_sum = m_sum + w;
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    m_cnt = 0; m_err = 1'b0; m_bad = 1'b0; m_sum = '0; tog = 1'b1;
    chk("enter_ready",     {63'h0, sif.s_ready}, 64'd1);
    chk("enter_word_cnt",  {55'h0, word_cnt},    64'd0);
    chk("enter_err",       {63'h0, err},         64'd0);
    chk("enter_done",      {63'h0, done},        64'd0);
    chk("enter_core_rstn", {63'h0, core_rst_n},  64'd0);
  endtask

  // mode 0: valid always high, 1: toggling, 2: random gaps
  task automatic send(input logic [31:0] w, input bit last, input int mode);
    bit sent = 1'b0;
    for (int t = 0; t < 64 && !sent; t++) begin
      case (mode)
        0:       sif.s_valid = 1'b1;
        1:       begin sif.s_valid = tog; tog = ~tog; end
        default: sif.s_valid = ($urandom_range(0, 99) >= 40);
      endcase
      sif.s_data = sif.s_valid ? w : $urandom;
      sif.s_last = sif.s_valid ? last : $urandom_range(0, 1);
      load_start = ($urandom_range(0, 7) == 0);
      if (sif.s_valid && sif.s_ready) begin
        model_xfer(w, last);
        sent = 1'b1;
      end
      @(negedge clk);
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    load_start  = 1'b0;
    if (!sent) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_check();
    int first_hi = -1;
    chk("hold_core_rstn", {63'h0, core_rst_n}, 64'd0);
    for (int j = 1; j <= REL + 4; j++) begin
      load_start = (j == 1);
      @(negedge clk);
      load_start = 1'b0;
      if (core_rst_n === 1'b1 && first_hi < 0) first_hi = j;
    end
    chk("release_cycle", 64'(first_hi), m_bad ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(REL + 1));
    chk("load_word_cnt", {55'h0, word_cnt}, 64'(m_cnt));
    chk("load_err", {63'h0, err}, {63'h0, m_err | m_bad});
    chk("load_core_rstn", {63'h0, core_rst_n}, {63'h0, !m_bad});
    if (!m_err) chk("load_done", {63'h0, done}, {63'h0, !m_bad});
    chk("load_ready_low", {63'h0, sif.s_ready}, 64'd0);
    chk("load_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_load(input int mode);
    start_load();
    for (int i = 0; i < img.size(); i++) send(img[i], i == img.size() - 1, mode);
    finish_check();
  endtask

  // Random image of n words; with checksum builds the last word is the sum
  // (plus an optional corruption offset).
  task automatic build_img(input int n, input logic [31:0] corrupt);
    logic [31:0] s = '0;
    img.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = $urandom;
      if (CSUM && i == n - 1) w = s + corrupt;
      s = s + w;
      img.push_back(w);
    end
  endtask

  task automatic idle_valid_probe(input string name);
    sif.s_valid = 1'b1;
    sif.s_data  = $urandom;
    sif.s_last  = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk(name, {63'h0, sif.s_ready}, 64'd0);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we",    {63'h0, mem_we},     64'd0);
    chk("rst_mem_addr",  {56'h0, mem_addr},   64'd0);
    chk("rst_mem_wdata", {32'h0, mem_wdata},  64'd0);
    chk("rst_core_rstn", {63'h0, core_rst_n}, 64'd0);
    chk("rst_word_cnt",  {55'h0, word_cnt},   64'd0);
    chk("rst_done",      {63'h0, done},       64'd0);
    chk("rst_err",       {63'h0, err},        64'd0);
    chk("rst_ready",     {63'h0, sif.s_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    idle_valid_probe("idle_ready_low");

    // basic four-word image, streaming every cycle
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back(32'h0000_0013 + 32'(i));
    if (CSUM) img[3] = img[0] + img[1] + img[2];
    run_load(0);

    idle_valid_probe("run_ready_low");

    // toggling valid, reload from RUN
    build_img(7, 32'h0);
    run_load(1);

    for (int k = 0; k < 5; k++) begin
      build_img($urandom_range(1, 20), 32'h0);
      run_load(2);
    end

    // reset mid-load aborts everything
    build_img(10, 32'h0);
    start_load();
    for (int i = 0; i < 4; i++) send(img[i], 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_mem_we",    {63'h0, mem_we},     64'd0);
    chk("abort_mem_addr",  {56'h0, mem_addr},   64'd0);
    chk("abort_mem_wdata", {32'h0, mem_wdata},  64'd0);
    chk("abort_core_rstn", {63'h0, core_rst_n}, 64'd0);
    chk("abort_word_cnt",  {55'h0, word_cnt},   64'd0);
    chk("abort_done",      {63'h0, done},       64'd0);
    chk("abort_err",       {63'h0, err},        64'd0);
    chk("abort_ready",     {63'h0, sif.s_ready}, 64'd0);
    chk("abort_queue",     64'(exp_q.size()),   64'd0);
    exp_q.delete();

    // overflow: two words beyond memory depth
    build_img(DEPTH + 2, 32'h0);
    run_load(0);

    // single-word image
    build_img(1, 32'h0);
    run_load(2);

`ifdef IMEM_LOADER_CSUM_EN
    img.delete();
    img.push_back(32'd1); img.push_back(32'd2); img.push_back(32'd3); img.push_back(32'd6);
    run_load(0);
    img[3] = 32'd7;
    run_load(0);
    build_img(9, 32'h100);
    run_load(2);
    build_img(9, 32'h0);
    run_load(2);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
